// File: rtl/uart_frame_parser.sv
// Command-frame parser behind the UART receiver: hunts for 55 AA, checks LEN and CHK,
// streams payload bytes to an external buffer and reports each frame as good or bad.
//
// state     | meaning
// ----------+----------------------------------------------
// S_IDLE    | hunting for the first header byte 0x55
// S_HDR1    | 0x55 seen, expecting 0xAA
// S_CMD     | next byte is CMD
// S_LEN     | next byte is LEN
// S_PAYLOAD | receiving LEN payload bytes
// S_CHK     | next byte is the checksum
module uart_frame_parser #(
    parameter int CLK_FREQ    = 27000000,
    parameter int TIMEOUT_CYC = 2700000,
    parameter int MAX_LEN     = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_done,
    input  logic [7:0]        uart_data,
    output logic              pld_wr_en,
    output logic [ADDR_W-1:0] pld_wr_addr,
    output logic [7:0]        pld_wr_data,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int             TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    if (CLK_FREQ < 1 || TIMEOUT_CYC < 1 || MAX_LEN < 1 || MAX_LEN > 255 ||
        MAX_LEN > (1 << ADDR_W)) begin : g_bad_params
        $error("uart_frame_parser: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t        state;
    logic          done_d;
    logic          byte_stb;
    logic [7:0]    cmd_r;
    logic [7:0]    len_r;
    logic [7:0]    sum_r;
    logic [7:0]    cnt_r;
    logic [TW-1:0] tmr;

    // uart_done is a level; only its rising edge counts as a new byte
    assign byte_stb = uart_done & ~done_d;
    assign busy     = (state != S_IDLE);

    // tmr counts down the idle cycles left before the frame is abandoned
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            done_d      <= 1'b0;
            cmd_r       <= 8'h00;
            len_r       <= 8'h00;
            sum_r       <= 8'h00;
            cnt_r       <= 8'h00;
            tmr         <= TMR_LOAD;
            pld_wr_en   <= 1'b0;
            pld_wr_addr <= '0;
            pld_wr_data <= 8'h00;
            frame_cmd   <= 8'h00;
            frame_len   <= 8'h00;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            done_d    <= uart_done;
            pld_wr_en <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (byte_stb) begin
                tmr <= TMR_LOAD;
                case (state)
                    S_IDLE: begin
                        if (uart_data == 8'h55) state <= S_HDR1;
                    end
                    S_HDR1: begin
                        if (uart_data == 8'hAA)      state <= S_CMD;
                        else if (uart_data != 8'h55) state <= S_IDLE;
                    end
                    S_CMD: begin
                        cmd_r <= uart_data;
                        sum_r <= uart_data;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        len_r <= uart_data;
                        sum_r <= sum_r + uart_data;
                        cnt_r <= 8'h00;
                        if (uart_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= S_IDLE;
                        end else if (uart_data == 8'h00) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        pld_wr_en   <= 1'b1;
                        pld_wr_addr <= ADDR_W'(cnt_r);
                        pld_wr_data <= uart_data;
                        sum_r       <= sum_r + uart_data;
                        cnt_r       <= cnt_r + 8'd1;
                        if (cnt_r == len_r - 8'd1) state <= S_CHK;
                    end
                    S_CHK: begin
                        if (uart_data == sum_r) begin
                            frame_ok  <= 1'b1;
                            frame_cmd <= cmd_r;
                            frame_len <= len_r;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (tmr == '0) begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_TMO;
                    state     <= S_IDLE;
                    tmr       <= TMR_LOAD;
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, header hunting, level-held
// uart_done, inter-byte timeout and mid-frame reset, with hand-computed expectations.
module tb_uart_frame_parser;

    localparam int ADDR_W = 5;
    localparam int TMO    = 500;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              uart_done = 1'b0;
    logic [7:0]        uart_data = 8'h00;
    logic              pld_wr_en;
    logic [ADDR_W-1:0] pld_wr_addr;
    logic [7:0]        pld_wr_data;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic              frame_ok;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    uart_frame_parser #(
        .CLK_FREQ   (27000000),
        .TIMEOUT_CYC(TMO),
        .MAX_LEN    (32),
        .ADDR_W     (ADDR_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_done  (uart_done),
        .uart_data  (uart_data),
        .pld_wr_en  (pld_wr_en),
        .pld_wr_addr(pld_wr_addr),
        .pld_wr_data(pld_wr_data),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observation log filled on falling edges, away from the active edge
    logic [ADDR_W-1:0] wa_q[$];
    logic [7:0]        wd_q[$];
    int                ok_cnt, err_cnt, both_cnt, ok_cyc, err_cyc, last_stb;
    logic [7:0]        ok_cmd, ok_len;
    logic              ok_busy;
    logic [1:0]        last_err;

    always @(negedge sys_clk) begin
        if (pld_wr_en) begin
            wa_q.push_back(pld_wr_addr);
            wd_q.push_back(pld_wr_data);
        end
        if (frame_ok) begin
            ok_cnt++;
            ok_cmd  = frame_cmd;
            ok_len  = frame_len;
            ok_busy = busy;
            ok_cyc  = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            last_err = err_code;
            err_cyc  = cyc;
        end
        if (frame_ok && frame_err) both_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ok_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    // Called at a falling edge with uart_done low; the byte strobes on the next rising edge
    task automatic send_byte(input logic [7:0] b, input int hold);
        uart_done = 1'b1;
        uart_data = b;
        last_stb  = cyc + 1;
        repeat (hold) @(negedge sys_clk);
        uart_done = 1'b0;
        uart_data = ~b;
        @(negedge sys_clk);
    endtask

    task automatic send_good(input int hold);
        send_byte(8'h55, hold); send_byte(8'hAA, hold);
        send_byte(8'h01, hold); send_byte(8'h03, hold);
        send_byte(8'h10, hold); send_byte(8'h20, hold);
        send_byte(8'h30, hold); send_byte(8'h64, hold);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (pld_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0h want 0", pld_wr_en); end
        checks++; if (pld_wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0h want 0", pld_wr_addr); end
        checks++; if (pld_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %0h want 0", pld_wr_data); end
        checks++; if ({frame_cmd, frame_len} !== 16'h0000) begin errors++; $display("FAIL reset_cmd_len got %0h want 0", {frame_cmd, frame_len}); end
        checks++; if ({frame_ok, frame_err, err_code} !== 4'h0) begin errors++; $display("FAIL reset_status got %0h want 0", {frame_ok, frame_err, err_code}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic check_good_result(input string tag);
        logic [7:0] exp_d [3];
        exp_d = '{8'h10, 8'h20, 8'h30};
        checks++; if (wd_q.size() !== 3) begin errors++; $display("FAIL %s_wr_count got %0d want 3", tag, wd_q.size()); end
        for (int i = 0; i < 3 && i < wd_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL %s_wr%0d got (%0h,%0h) want (%0h,%0h)", tag, i, wa_q[i], wd_q[i], i, exp_d[i]);
            end
        end
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL %s_pulses got ok=%0d err=%0d want ok=1 err=0", tag, ok_cnt, err_cnt); end
        checks++; if (ok_cmd !== 8'h01 || ok_len !== 8'h03) begin errors++; $display("FAIL %s_cmd_len got %0h/%0h want 01/03", tag, ok_cmd, ok_len); end
        checks++; if (ok_cyc !== last_stb) begin errors++; $display("FAIL %s_ok_latency got edge %0d want %0d", tag, ok_cyc, last_stb); end
        checks++; if (ok_busy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0h/%0h want 0/0", tag, ok_busy, busy); end
    endtask

    task automatic test_good_frame();
        clear_log();
        send_good(1);
        check_good_result("good");
    endtask

    task automatic test_bad_frames();
        clear_log();
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h02, 1);
        send_byte(8'h01, 1); send_byte(8'hFF, 1); send_byte(8'h00, 1);
        repeat (3) @(negedge sys_clk);
        checks++; if (wd_q.size() !== 1) begin errors++; $display("FAIL chk_wr_count got %0d want 1", wd_q.size()); end
        if (wd_q.size() > 0) begin
            checks++; if (wa_q[0] !== '0 || wd_q[0] !== 8'hFF) begin errors++; $display("FAIL chk_wr0 got (%0h,%0h) want (0,ff)", wa_q[0], wd_q[0]); end
        end
        checks++; if (err_cnt !== 1 || ok_cnt !== 0 || last_err !== 2'd1) begin errors++; $display("FAIL chk_err got err=%0d ok=%0d code=%0d want 1/0/1", err_cnt, ok_cnt, last_err); end
        checks++; if (frame_cmd !== 8'h01 || frame_len !== 8'h03) begin errors++; $display("FAIL chk_cmd_len_kept got %0h/%0h want 01/03", frame_cmd, frame_len); end

        clear_log();
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1); send_byte(8'h21, 1);
        repeat (3) @(negedge sys_clk);
        checks++; if (err_cnt !== 1 || last_err !== 2'd2 || err_cyc !== last_stb) begin errors++; $display("FAIL len_err got err=%0d code=%0d edge=%0d want 1/2/%0d", err_cnt, last_err, err_cyc, last_stb); end
        checks++; if (wd_q.size() !== 0 || busy !== 1'b0 || err_code !== 2'd2) begin errors++; $display("FAIL len_no_writes got wr=%0d busy=%0h code=%0d want 0/0/2", wd_q.size(), busy, err_code); end
    endtask

    task automatic test_zero_len_hunt();
        clear_log();
        send_byte(8'h12, 1); send_byte(8'h55, 1); send_byte(8'h55, 1); send_byte(8'hAA, 1);
        send_byte(8'h07, 1); send_byte(8'h00, 1); send_byte(8'h07, 1);
        repeat (3) @(negedge sys_clk);
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL zlen_pulses got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt); end
        checks++; if (frame_cmd !== 8'h07 || frame_len !== 8'h00) begin errors++; $display("FAIL zlen_cmd_len got %0h/%0h want 07/00", frame_cmd, frame_len); end
        checks++; if (wd_q.size() !== 0) begin errors++; $display("FAIL zlen_writes got %0d want 0", wd_q.size()); end
    endtask

    // Held 400 cycles per byte so the 500-cycle inter-byte timeout stays out of the way
    task automatic test_level_done();
        clear_log();
        send_good(400);
        check_good_result("level");
    endtask

    task automatic test_timeout();
        int s;
        clear_log();
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1);
        s = last_stb;
        for (int k = 0; k < 700 && err_cnt == 0; k++) @(negedge sys_clk);
        checks++; if (err_cnt !== 1 || last_err !== 2'd3) begin errors++; $display("FAIL tmo_err got err=%0d code=%0d want 1/3", err_cnt, last_err); end
        checks++; if (err_cyc - s !== TMO) begin errors++; $display("FAIL tmo_latency got %0d want %0d", err_cyc - s, TMO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %0h want 0", busy); end

        clear_log();
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1);
        s = last_stb;
        while (cyc < s + TMO - 1) @(negedge sys_clk);
        send_byte(8'h00, 1);
        checks++; if (last_stb - s !== TMO) begin errors++; $display("FAIL tmo_edge_setup got %0d want %0d", last_stb - s, TMO); end
        send_byte(8'h01, 1);
        repeat (3) @(negedge sys_clk);
        checks++; if (err_cnt !== 0 || ok_cnt !== 1) begin errors++; $display("FAIL tmo_edge_byte_wins got err=%0d ok=%0d want 0/1", err_cnt, ok_cnt); end
        checks++; if (frame_cmd !== 8'h01 || frame_len !== 8'h00) begin errors++; $display("FAIL tmo_edge_cmd_len got %0h/%0h want 01/00", frame_cmd, frame_len); end
    endtask

    task automatic test_reset_mid_payload();
        clear_log();
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h02, 1);
        send_byte(8'h04, 1); send_byte(8'hA5, 1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        checks++; if ({pld_wr_en, pld_wr_addr, pld_wr_data} !== '0) begin errors++; $display("FAIL rstmid_wr got %0h want 0", {pld_wr_en, pld_wr_addr, pld_wr_data}); end
        checks++; if ({frame_cmd, frame_len, frame_ok, frame_err, err_code} !== '0) begin errors++; $display("FAIL rstmid_status got %0h want 0", {frame_cmd, frame_len, frame_ok, frame_err, err_code}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0h want 0", busy); end
        @(negedge sys_clk);
        checks++; if (err_cnt !== 0 || ok_cnt !== 0) begin errors++; $display("FAIL rstmid_no_pulse got err=%0d ok=%0d want 0/0", err_cnt, ok_cnt); end
        clear_log();
        send_good(1);
        check_good_result("after_rst");
    endtask

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ok_err_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_zero_len_hunt();
        test_level_done();
        test_timeout();
        test_reset_mid_payload();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
